alu_rr_arbiter: RTL
===================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational ArithmeticLogicUnit among NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshake per requester, registered ALU operands.
//  Single response channel returns the result, the flag and the requester id.
//  Sits between the pipeline/requester units and the ALU; the ALU is instanced outside.
// PARAMETERS
//  BUS_WIDTH  8  operand/result width; must match the attached ALU
//  NUM_REQ    4  requester count, 2..16
//  ID_W       2  requester id width, = clog2(NUM_REQ)
// PORTS
//  clk         in   1                clock, rising edge
//  reset       in   1                reset, synchronous, active-high
//  req_valid   in   NUM_REQ          request pending, one bit per requester
//  req_ready   out  NUM_REQ          one-hot grant; the request is accepted on valid&ready
//  req_a       in   NUM_REQ*W        operand A, requester i at [i*W +: W]
//  req_b       in   NUM_REQ*W        operand B, same packing
//  req_cmd     in   NUM_REQ*4        ALU command, requester i at [i*4 +: 4]
//  alu_a       out  W                operand A register, drives the ALU
//  alu_b       out  W                operand B register, drives the ALU
//  alu_cmd     out  4                command register, drives the ALU
//  alu_out     in   W                ALU result
//  alu_ovf     in   1                ALU overflow/compare flag
//  resp_valid  out  1                response held valid
//  resp_ready  in   1                consumer accepts the response
//  resp_id     out  ID_W             id of the requester that issued the op
//  resp_out    out  W                captured result
//  resp_flag   out  1                captured flag, masked per the rules below
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0.
//    alu_a/alu_b/resp_out=0, alu_cmd=4'hF (ALU default case), resp_id=0, resp_flag=0.
//  Reset mid-operation: an in-flight op is dropped; no response is ever produced for it.
//  FSM, three states:
//   IDLE: pick the first set req_valid, searching from rr_ptr upward with wrap.
//     req_ready is combinational, one-hot on the winner, in IDLE only.
//     On a grant: latch that requester's a/b/cmd into alu_*, set id, rr_ptr = winner+1 (wraps
//     NUM_REQ-1 -> 0), go to EXEC. With no valid request, stay in IDLE.
//   EXEC: the ALU settles on the registered operands.
//     At the end of this cycle capture resp_out=alu_out.
//     Capture resp_flag = alu_ovf only for cmd 0,7,8,9; otherwise capture 0. This masks the ALU's
//     stale flag on sub and logic ops.
//     Set resp_valid=1 and go to RESP.
//   RESP: hold resp_* stable while resp_valid=1 and resp_ready=0.
//     On resp_ready: clear resp_valid and go to IDLE.
//     Arbitration happens in the next cycle; a grant is never issued in the same cycle as the
//     response handshake.
//  Latency: grant at cycle T -> resp_valid=1 from T+2. Peak throughput is 1 op per 3 cycles.
//  req_ready is 0 in EXEC and RESP. Requesters must hold valid/operands until granted.
//    A valid dropped before its grant is legal and is simply skipped.
//  Illegal cmd (10..15) is passed to the ALU unchanged; resp_out/resp_flag are captured as
//    produced, with the flag masked to 0.
//  alu_* stay at their last values after the op; there is no toggling while idle.
//  Fairness: with all requesters valid, grants rotate 0,1,2,...,N-1,0.
//    Worst-case wait is NUM_REQ-1 ops.
// STRUCTURE
//  Package alu_pkg: ALU_ADD=0, SUB=1, SHL=2, OR=3, AND=4, XOR=5, ROR=6, EQ=7, GT=8, LT=9;
//    ALU_CMD_W=4; localparam flag_valid(cmd) function; FSM state enum.
//  Sub-module rr_picker (NUM_REQ): inputs req, ptr; outputs onehot and index.
//    Purely combinational; reused by other shared-resource arbiters.
//  Top: FSM, operand/response registers and input-slice muxing.
// TESTING
//  1. Reset held 3 cycles mid-EXEC -> resp_valid=0, alu_cmd=F, no response after release.
//  2. Req0 ADD a=8'h7F b=8'h01 -> grant 0, resp at T+2: out=8'h80 flag=alu_ovf(0) id=0.
//  3. Req1 ADD 8'hFF+8'h01 -> out=8'h00 flag=1.
//     Then req1 SUB 8'h05-8'h03 -> out=8'h02 flag=0 (masked).
//  4. All 4 valid constantly, resp_ready=1 -> grant order 0,1,2,3,0.
//     One op every 3 cycles, ids match.
//  5. resp_ready=0 for 5 cycles with req2 valid -> resp held stable and req_ready=0.
//     Req2 is granted in the cycle after the resp handshake.
//  6. Req3 GT a=9 b=4 -> flag=1; cmd=4'hC -> out=0 flag=0.
//     Req3 rotate-right case cmd 6 -> out matches the ALU model.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: command codes, flag qualification
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam int ALU_CMD_W = 4;

  localparam logic [ALU_CMD_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CMD_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_CMD_W-1:0] ALU_SHL = 4'd2;
  localparam logic [ALU_CMD_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_CMD_W-1:0] ALU_AND = 4'd4;
  localparam logic [ALU_CMD_W-1:0] ALU_XOR = 4'd5;
  localparam logic [ALU_CMD_W-1:0] ALU_ROR = 4'd6;
  localparam logic [ALU_CMD_W-1:0] ALU_EQ  = 4'd7;
  localparam logic [ALU_CMD_W-1:0] ALU_GT  = 4'd8;
  localparam logic [ALU_CMD_W-1:0] ALU_LT  = 4'd9;
  localparam logic [ALU_CMD_W-1:0] ALU_NOP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Only carry-out and compare results produce a meaningful flag; all other ops
  // leave whatever the ALU last drove, so it is forced to 0.
  function automatic logic flag_valid(input logic [ALU_CMD_W-1:0] cmd);
    return (cmd == ALU_ADD) || (cmd == ALU_EQ) || (cmd == ALU_GT) || (cmd == ALU_LT);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Returns the winner as one-hot and as an index; onehot is zero when nothing is requested.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  logic found;

  always_comb begin
    found  = 1'b0;
    onehot = '0;
    index  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        index     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared combinational ALU: grants one requester,
// registers its operands, captures the ALU result one cycle later, holds it until taken.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*ALU_CMD_W-1:0]   req_cmd,
  output logic [BUS_WIDTH-1:0]           alu_a,
  output logic [BUS_WIDTH-1:0]           alu_b,
  output logic [ALU_CMD_W-1:0]           alu_cmd,
  input  logic [BUS_WIDTH-1:0]           alu_out,
  input  logic                           alu_ovf,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_W-1:0]                resp_id,
  output logic [BUS_WIDTH-1:0]           resp_out,
  output logic                           resp_flag
);

  arb_state_e state, state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] win_oh;
  logic               grant;

  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] a_vec;
  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] b_vec;
  logic [NUM_REQ-1:0][ALU_CMD_W-1:0] cmd_vec;

  assign a_vec   = req_a;
  assign b_vec   = req_b;
  assign cmd_vec = req_cmd;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .index  (win_idx)
  );

  assign ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Grants only in IDLE, so a response handshake and a new grant never share a cycle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = win_oh;
        if (|win_oh) begin
          grant     = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers keep their last values between ops so the ALU inputs stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= ALU_NOP;
      resp_id    <= '0;
      resp_out   <= '0;
      resp_flag  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      if (grant) begin
        alu_a   <= a_vec[win_idx];
        alu_b   <= b_vec[win_idx];
        alu_cmd <= cmd_vec[win_idx];
        resp_id <= win_idx;
        rr_ptr  <= ptr_nxt;
      end
      if (state == ST_EXEC) begin
        resp_out   <= alu_out;
        resp_flag  <= flag_valid(alu_cmd) & alu_ovf;
        resp_valid <= 1'b1;
      end
      if (state == ST_RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule
